// File: rtl/write_rsp_xbar.sv
// write_rsp_xbar: return-path crossbar for the vector cache write channel.
// Completions from 4 cache channels enter 2-deep skid FIFOs and are routed by
// source id to the requesters, each output owning a locked round-robin
// arbiter. Every accepted completion releases its data-buffer entry one
// cycle later; completions with an out-of-range id are dropped and flagged.
module write_rsp_xbar #(
  parameter int W_REQ_NUM          = 8,
  parameter int SRC_WIDTH          = 3,
  parameter int TXNID_WIDTH        = 8,
  parameter int DB_ENTRY_IDX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [3:0]                      wr_rsp_vld,
  input  logic [4*SRC_WIDTH-1:0]          wr_rsp_src,
  input  logic [4*TXNID_WIDTH-1:0]        wr_rsp_txnid,
  input  logic [4*DB_ENTRY_IDX_WIDTH-1:0] wr_rsp_db_id,
  output logic [3:0]                      wr_rsp_rdy,
  output logic [W_REQ_NUM-1:0]            wr_done_vld,
  output logic [W_REQ_NUM*TXNID_WIDTH-1:0] wr_done_txnid,
  output logic [W_REQ_NUM*2-1:0]          wr_done_chnl,
  input  logic [W_REQ_NUM-1:0]            wr_done_rdy,
  output logic [3:0]                      dealloc_vld,
  output logic [4*DB_ENTRY_IDX_WIDTH-1:0] dealloc_idx,
  output logic [3:0]                      src_err
);

  localparam int NCH = 4;

  // Per-channel 2-entry FIFO storage and pointers
  logic [NCH-1:0][1:0][SRC_WIDTH-1:0]   fifo_src;
  logic [NCH-1:0][1:0][TXNID_WIDTH-1:0] fifo_txnid;
  logic [NCH-1:0]                       rd_ptr;
  logic [NCH-1:0]                       wr_ptr;
  logic [NCH-1:0][1:0]                  count;
  logic [NCH-1:0][1:0]                  next_count;

  logic [NCH-1:0]                       push;
  logic [NCH-1:0]                       pop;
  logic [NCH-1:0]                       head_vld;
  logic [NCH-1:0]                       head_illegal;
  logic [NCH-1:0][SRC_WIDTH-1:0]        head_src;
  logic [NCH-1:0][TXNID_WIDTH-1:0]      head_txnid;

  // Per-requester arbitration state and current selection
  logic [W_REQ_NUM-1:0][1:0]            rr_ptr;
  logic [W_REQ_NUM-1:0][1:0]            gnt;
  logic [W_REQ_NUM-1:0]                 lock;
  logic [W_REQ_NUM-1:0][1:0]            sel_chnl;
  logic [W_REQ_NUM-1:0]                 sel_vld;
  logic [1:0]                           scan_chnl;

  // Decode each FIFO head and flag ids that have no matching requester
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      head_vld[i]     = (count[i] != 2'd0);
      head_src[i]     = fifo_src[i][rd_ptr[i]];
      head_txnid[i]   = fifo_txnid[i][rd_ptr[i]];
      head_illegal[i] = head_vld[i] && (32'(head_src[i]) >= 32'(W_REQ_NUM));
      push[i]         = wr_rsp_vld[i] && wr_rsp_rdy[i];
    end
  end

  // Grant per requester: a locked output keeps its channel, otherwise the
  // first channel from rr_ptr onward whose head targets this requester wins
  always_comb begin
    sel_vld   = '0;
    sel_chnl  = '0;
    scan_chnl = 2'd0;
    for (int j = 0; j < W_REQ_NUM; j++) begin
      if (lock[j]) begin
        sel_vld[j]  = 1'b1;
        sel_chnl[j] = gnt[j];
      end else begin
        for (int o = 0; o < NCH; o++) begin
          scan_chnl = rr_ptr[j] + 2'(o);
          if (!sel_vld[j] && head_vld[scan_chnl] &&
              (head_src[scan_chnl] == SRC_WIDTH'(j))) begin
            sel_vld[j]  = 1'b1;
            sel_chnl[j] = scan_chnl;
          end
        end
      end
    end
  end

  // A head leaves its FIFO when dropped as illegal or accepted by its output
  always_comb begin
    pop = head_illegal;
    for (int j = 0; j < W_REQ_NUM; j++) begin
      if (sel_vld[j] && wr_done_rdy[j]) begin
        pop[sel_chnl[j]] = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      next_count[i] = count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
    end
  end

  // Drive requester outputs from the granted heads, zero when idle
  always_comb begin
    wr_done_vld   = sel_vld;
    wr_done_txnid = '0;
    wr_done_chnl  = '0;
    for (int j = 0; j < W_REQ_NUM; j++) begin
      if (sel_vld[j]) begin
        wr_done_txnid[j*TXNID_WIDTH +: TXNID_WIDTH] = head_txnid[sel_chnl[j]];
        wr_done_chnl[j*2 +: 2]                      = sel_chnl[j];
      end
    end
  end

  // FIFO storage, occupancy and the registered ready derived from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_src   <= '0;
      fifo_txnid <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wr_rsp_rdy <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) begin
          fifo_src[i][wr_ptr[i]]   <= wr_rsp_src[i*SRC_WIDTH +: SRC_WIDTH];
          fifo_txnid[i][wr_ptr[i]] <= wr_rsp_txnid[i*TXNID_WIDTH +: TXNID_WIDTH];
          wr_ptr[i]                <= ~wr_ptr[i];
        end
        if (pop[i]) begin
          rd_ptr[i] <= ~rd_ptr[i];
        end
        count[i]      <= next_count[i];
        wr_rsp_rdy[i] <= (next_count[i] < 2'd2);
      end
    end
  end

  // One-cycle entry release on every accepted completion, and drop flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dealloc_vld <= '0;
      dealloc_idx <= '0;
      src_err     <= '0;
    end else begin
      dealloc_vld <= push;
      src_err     <= head_illegal;
      for (int i = 0; i < NCH; i++) begin
        dealloc_idx[i*DB_ENTRY_IDX_WIDTH +: DB_ENTRY_IDX_WIDTH] <=
          push[i] ? wr_rsp_db_id[i*DB_ENTRY_IDX_WIDTH +: DB_ENTRY_IDX_WIDTH] : '0;
      end
    end
  end

  // Advance round-robin on handshake; lock the grant while the requester stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      gnt    <= '0;
      lock   <= '0;
    end else begin
      for (int j = 0; j < W_REQ_NUM; j++) begin
        if (sel_vld[j] && wr_done_rdy[j]) begin
          rr_ptr[j] <= sel_chnl[j] + 2'd1;
          lock[j]   <= 1'b0;
        end else if (sel_vld[j]) begin
          lock[j] <= 1'b1;
          gnt[j]  <= sel_chnl[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_write_rsp_xbar.sv
// tb_write_rsp_xbar: directed scenarios followed by random traffic, every
// cycle checked against a queue-based model of the crossbar behaviour.
module tb_write_rsp_xbar;

  localparam int NREQ = 6;

  logic        clk;
  logic        rst_n;
  logic [3:0]  wr_rsp_vld;
  logic [11:0] wr_rsp_src;
  logic [31:0] wr_rsp_txnid;
  logic [19:0] wr_rsp_db_id;
  logic [3:0]  wr_rsp_rdy;
  logic [NREQ-1:0]   wr_done_vld;
  logic [NREQ*8-1:0] wr_done_txnid;
  logic [NREQ*2-1:0] wr_done_chnl;
  logic [NREQ-1:0]   wr_done_rdy;
  logic [3:0]  dealloc_vld;
  logic [19:0] dealloc_idx;
  logic [3:0]  src_err;

  int assertCount = 0;
  int failCount   = 0;

  // Six requesters with 3-bit ids so that ids 6 and 7 are out of range
  write_rsp_xbar #(
    .W_REQ_NUM(NREQ), .SRC_WIDTH(3), .TXNID_WIDTH(8), .DB_ENTRY_IDX_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_rsp_vld(wr_rsp_vld), .wr_rsp_src(wr_rsp_src),
    .wr_rsp_txnid(wr_rsp_txnid), .wr_rsp_db_id(wr_rsp_db_id),
    .wr_rsp_rdy(wr_rsp_rdy),
    .wr_done_vld(wr_done_vld), .wr_done_txnid(wr_done_txnid),
    .wr_done_chnl(wr_done_chnl), .wr_done_rdy(wr_done_rdy),
    .dealloc_vld(dealloc_vld), .dealloc_idx(dealloc_idx), .src_err(src_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending completions per channel, plus the
  // round-robin start, lock state and the registered outputs expected next
  typedef struct packed {
    logic [2:0] src;
    logic [7:0] txnid;
  } ent_t;

  ent_t        mq [4][$];
  int          rrp  [NREQ];
  bit          lk   [NREQ];
  int          lkch [NREQ];
  logic [3:0]  mRdy;
  logic [3:0]  mDvld;
  logic [19:0] mDidx;
  logic [3:0]  mErr;

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, compare every output against the model, then
  // advance the model across the coming rising edge
  task automatic applyStimulus(input logic [3:0] vld, input logic [11:0] src,
                               input logic [31:0] tx, input logic [19:0] db,
                               input logic [NREQ-1:0] drdy);
    logic [NREQ-1:0]   eVld;
    logic [NREQ*8-1:0] eTx;
    logic [NREQ*8-1:0] txMask;
    logic [NREQ*2-1:0] eCh;
    logic [NREQ*2-1:0] chMask;
    logic [19:0]       idxMask;
    logic [3:0]        errNext;
    logic [3:0]        pushNow;
    int                gch [NREQ];
    ent_t              e;
    @(negedge clk);
    wr_rsp_vld   = vld;
    wr_rsp_src   = src;
    wr_rsp_txnid = tx;
    wr_rsp_db_id = db;
    wr_done_rdy  = drdy;
    #1;
    eVld = '0; eTx = '0; eCh = '0; txMask = '0; chMask = '0; idxMask = '0;
    for (int j = 0; j < NREQ; j++) begin
      gch[j] = -1;
      if (lk[j]) begin
        gch[j] = lkch[j];
      end else begin
        for (int o = 0; o < 4; o++) begin
          int k;
          k = (rrp[j] + o) % 4;
          if (gch[j] < 0 && mq[k].size() > 0 && int'(mq[k][0].src) == j) gch[j] = k;
        end
      end
      if (gch[j] >= 0) begin
        eVld[j]          = 1'b1;
        eTx[j*8 +: 8]    = mq[gch[j]][0].txnid;
        eCh[j*2 +: 2]    = 2'(gch[j]);
        txMask[j*8 +: 8] = 8'hFF;
        chMask[j*2 +: 2] = 2'b11;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (mDvld[i]) idxMask[i*5 +: 5] = 5'h1F;
    end
    checkOutput("wr_done_vld",   64'(wr_done_vld), 64'(eVld));
    checkOutput("wr_done_txnid", 64'(wr_done_txnid & txMask), 64'(eTx));
    checkOutput("wr_done_chnl",  64'(wr_done_chnl & chMask), 64'(eCh));
    checkOutput("wr_rsp_rdy",    64'(wr_rsp_rdy), 64'(mRdy));
    checkOutput("dealloc_vld",   64'(dealloc_vld), 64'(mDvld));
    checkOutput("dealloc_idx",   64'(dealloc_idx & idxMask), 64'(mDidx));
    checkOutput("src_err",       64'(src_err), 64'(mErr));
    // Out-of-range heads are discarded straight away
    for (int i = 0; i < 4; i++) begin
      errNext[i] = (mq[i].size() > 0) && (int'(mq[i][0].src) >= NREQ);
      if (errNext[i]) void'(mq[i].pop_front());
    end
    // Accepted outputs consume their head; stalled outputs hold their channel
    for (int j = 0; j < NREQ; j++) begin
      if (gch[j] >= 0) begin
        if (drdy[j]) begin
          void'(mq[gch[j]].pop_front());
          rrp[j] = (gch[j] + 1) % 4;
          lk[j]  = 1'b0;
        end else begin
          lk[j]   = 1'b1;
          lkch[j] = gch[j];
        end
      end
    end
    // New completions are taken only where the channel currently shows ready
    for (int i = 0; i < 4; i++) begin
      pushNow[i] = vld[i] && mRdy[i];
      if (pushNow[i]) begin
        e.src   = src[i*3 +: 3];
        e.txnid = tx[i*8 +: 8];
        mq[i].push_back(e);
      end
      mDidx[i*5 +: 5] = pushNow[i] ? db[i*5 +: 5] : 5'd0;
    end
    mDvld = pushNow;
    mErr  = errNext;
    for (int i = 0; i < 4; i++) mRdy[i] = (mq[i].size() < 2);
  endtask

  // Assert reset between edges, check everything is cleared at once, then
  // release and check ready stays low until the following edge
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    wr_rsp_vld   = '0;
    wr_rsp_src   = '0;
    wr_rsp_txnid = '0;
    wr_rsp_db_id = '0;
    #1;
    checkOutput("rst_wr_done_vld",   64'(wr_done_vld), 64'd0);
    checkOutput("rst_wr_done_txnid", 64'(wr_done_txnid), 64'd0);
    checkOutput("rst_wr_done_chnl",  64'(wr_done_chnl), 64'd0);
    checkOutput("rst_wr_rsp_rdy",    64'(wr_rsp_rdy), 64'd0);
    checkOutput("rst_dealloc_vld",   64'(dealloc_vld), 64'd0);
    checkOutput("rst_dealloc_idx",   64'(dealloc_idx), 64'd0);
    checkOutput("rst_src_err",       64'(src_err), 64'd0);
    for (int i = 0; i < 4; i++) mq[i].delete();
    for (int j = 0; j < NREQ; j++) begin
      rrp[j] = 0; lk[j] = 1'b0; lkch[j] = 0;
    end
    mDvld = '0; mDidx = '0; mErr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_before_first_edge", 64'(wr_rsp_rdy), 64'd0);
    mRdy = 4'hF;
  endtask

  localparam logic [NREQ-1:0] ALL_RDY = '1;

  initial begin
    logic [11:0] rs;
    logic [31:0] rt;
    logic [19:0] rd;
    logic [NREQ-1:0] rr;
    rst_n        = 1'b1;
    wr_rsp_vld   = '0;
    wr_rsp_src   = '0;
    wr_rsp_txnid = '0;
    wr_rsp_db_id = '0;
    wr_done_rdy  = '1;
    mRdy = '0;
    doReset();

    // Single path: ch2 -> requester 5, entry 7 released next cycle
    applyStimulus(4'b0100, 12'(5 << 6), 32'h003A_0000, 20'(7 << 10), ALL_RDY);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    $display("[TB] single path step checked");
    checkOutput("single_vld",     64'(wr_done_vld), 64'(6'b100000));
    checkOutput("single_txnid",   64'(wr_done_txnid[5*8 +: 8]), 64'h3A);
    checkOutput("single_chnl",    64'(wr_done_chnl[5*2 +: 2]), 64'd2);
    checkOutput("single_dealloc", 64'(dealloc_vld), 64'(4'b0100));
    checkOutput("single_idx",     64'(dealloc_idx[2*5 +: 5]), 64'd7);

    // Contention: all four channels target requester 1 in the same cycle
    applyStimulus(4'b1111, {3'd1, 3'd1, 3'd1, 3'd1}, 32'h1312_1110, 20'd0, ALL_RDY);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
      checkOutput("rr_order", 64'(wr_done_txnid[1*8 +: 8]), 64'(8'h10 + n));
    end
    // rr pointer back at 0: ch0 must beat ch3 on a fresh tie
    applyStimulus(4'b1001, {3'd1, 3'd0, 3'd0, 3'd1}, 32'h5300_0050, 20'd0, ALL_RDY);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("rr_wrap_chnl", 64'(wr_done_chnl[1*2 +: 2]), 64'd0);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);

    // Lock: output 3 stalls on ch1's 0x22 while ch0 arrives with 0x20
    applyStimulus(4'b0010, 12'(3 << 3), 32'h0000_2200, 20'd0, 6'b110111);
    applyStimulus(4'b0001, 12'd3, 32'h0000_0020, 20'd0, 6'b110111);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, 6'b110111);
    checkOutput("lock_hold_txnid", 64'(wr_done_txnid[3*8 +: 8]), 64'h22);
    checkOutput("lock_hold_chnl",  64'(wr_done_chnl[3*2 +: 2]), 64'd1);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("lock_release_txnid", 64'(wr_done_txnid[3*8 +: 8]), 64'h22);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("lock_next_txnid", 64'(wr_done_txnid[3*8 +: 8]), 64'h20);
    checkOutput("lock_next_chnl",  64'(wr_done_chnl[3*2 +: 2]), 64'd0);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);

    // Backpressure: requester 0 stalled while ch0 offers three completions
    applyStimulus(4'b0001, 12'd0, 32'h30, 20'd0, 6'b111110);
    applyStimulus(4'b0001, 12'd0, 32'h31, 20'd0, 6'b111110);
    applyStimulus(4'b0001, 12'd0, 32'h32, 20'd0, 6'b111110);
    checkOutput("full_rdy_low", 64'(wr_rsp_rdy[0]), 64'd0);
    applyStimulus(4'b0001, 12'd0, 32'h32, 20'd0, 6'b111110);
    applyStimulus(4'b0001, 12'd0, 32'h32, 20'd0, ALL_RDY);
    checkOutput("full_order_0", 64'(wr_done_txnid[7:0]), 64'h30);
    applyStimulus(4'b0001, 12'd0, 32'h32, 20'd0, ALL_RDY);
    checkOutput("full_order_1", 64'(wr_done_txnid[7:0]), 64'h31);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("full_order_2", 64'(wr_done_txnid[7:0]), 64'h32);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("full_rdy_back", 64'(wr_rsp_rdy[0]), 64'd1);

    // Illegal source: ch3 sends id 7 with entry 9
    applyStimulus(4'b1000, 12'(7 << 9), 32'h7700_0000, 20'(9 << 15), ALL_RDY);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("illegal_dealloc", 64'(dealloc_vld), 64'(4'b1000));
    checkOutput("illegal_idx",     64'(dealloc_idx[3*5 +: 5]), 64'd9);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("illegal_err",  64'(src_err), 64'(4'b1000));
    checkOutput("illegal_none", 64'(wr_done_vld), 64'd0);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    checkOutput("illegal_err_once", 64'(src_err), 64'd0);

    // Reset mid-flight with two entries queued on ch1 behind a stalled output
    applyStimulus(4'b0010, 12'(2 << 3), 32'h0000_4000, 20'd0, 6'b111011);
    applyStimulus(4'b0010, 12'(2 << 3), 32'h0000_4100, 20'd0, 6'b111011);
    applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, 6'b111011);
    doReset();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
      checkOutput("post_reset_quiet", 64'(wr_done_vld), 64'd0);
    end

    // Random traffic, including out-of-range ids and stalled requesters
    for (int n = 0; n < 400; n++) begin
      rs = 12'($urandom);
      rt = $urandom;
      rd = 20'($urandom);
      rr = NREQ'($urandom | $urandom);
      applyStimulus(4'($urandom), rs, rt, rd, rr);
    end
    for (int n = 0; n < 8; n++) begin
      applyStimulus(4'b0000, 12'd0, 32'd0, 20'd0, ALL_RDY);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/write_rsp_xbar.md
Name: write_rsp_xbar

Overview:
Return-path crossbar for the vector cache write channel. It takes write completions from the 4 cache channels and routes each one to the originating write requester by source id. Each input has a 2-entry skid FIFO, and each output has a locked round-robin arbiter. Each accepted completion also produces a one-cycle data-buffer entry release back to the per-channel allocator.

Parameters:
W_REQ_NUM, 8, number of write requesters (outputs)
SRC_WIDTH, 3, requester id width; must be at least $clog2(W_REQ_NUM)
TXNID_WIDTH, 8, transaction id width
DB_ENTRY_IDX_WIDTH, 5, data-buffer entry index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wr_rsp_vld  input  4  completion valid per cache channel
wr_rsp_src  input  4 x SRC_WIDTH  destination requester id
wr_rsp_txnid  input  4 x TXNID_WIDTH  transaction id to return
wr_rsp_db_id  input  4 x DB_ENTRY_IDX_WIDTH  data-buffer entry used by the write
wr_rsp_rdy  output  4  per-channel ready, registered
wr_done_vld  output  W_REQ_NUM  completion valid per requester
wr_done_txnid  output  W_REQ_NUM x TXNID_WIDTH  returned transaction id
wr_done_chnl  output  W_REQ_NUM x 2  cache channel that served the write
wr_done_rdy  input  W_REQ_NUM  requester ready
dealloc_vld  output  4  data-buffer entry release pulse, no backpressure
dealloc_idx  output  4 x DB_ENTRY_IDX_WIDTH  released entry index
src_err  output  4  pulse: illegal source id dropped

Behaviour:
- Single clock domain. rst_n is asynchronous assert, active low. Registers take reset values immediately when rst_n is low.
- Reset values:
  - FIFOs empty, all counts 0.
  - rr_ptr[j] = 0; lock[j] = 0.
  - wr_rsp_rdy = 0, dealloc_vld = 0, dealloc_idx = 0, src_err = 0, wr_done_vld = 0.
  - wr_rsp_rdy rises on the first clk edge after rst_n deasserts.
- Input FIFO (per channel i, depth 2):
  - Push when wr_rsp_vld[i] && wr_rsp_rdy[i]; stores {src, txnid}.
  - wr_rsp_rdy[i] is a register equal to (next_count < 2). There is no combinational path from wr_done_rdy to wr_rsp_rdy.
  - If a push and a pop happen in the same cycle, the count is unchanged.
  - No push is possible at count 2. If a pop occurs at count 2, rdy returns to 1 on the next cycle.
- Dealloc:
  - An input handshake on channel i at cycle T gives dealloc_vld[i] = 1 and dealloc_idx[i] = wr_rsp_db_id[i] at T+1, for exactly one cycle.
  - Back-to-back handshakes give back-to-back pulses.
- Illegal source (head src >= W_REQ_NUM):
  - The head is popped in the cycle it becomes head, without arbitration.
  - src_err[i] pulses for 1 cycle, registered, at head+1.
  - The entry is never presented on any output.
- Output arbitration (per requester j):
  - Candidates are channels k whose FIFO is non-empty and whose head src == j.
  - Search order is rr_ptr[j], rr_ptr[j]+1, ... mod 4; the first candidate wins.
  - wr_done_vld[j], wr_done_txnid[j] and wr_done_chnl[j] are combinational from the granted head.
- Lock:
  - If wr_done_vld[j] && !wr_done_rdy[j], set lock[j] and hold the grant register gnt[j].
  - While locked, the output keeps the same channel and the same payload until handshake, even if a higher-priority candidate appears.
- On handshake with granted channel k:
  - Pop FIFO k.
  - rr_ptr[j] <= k+1 mod 4.
  - lock[j] <= 0.
- Multi-output pops: one FIFO head goes to exactly one output, so at most one pop per FIFO per cycle. Different outputs may pop different FIFOs in the same cycle.
- Latency:
  - Input handshake at T gives wr_done_vld at T+1 if the output is free and no other candidate wins.
  - Sustained throughput is 1 completion per cycle per channel when all readies are held high.
- Ordering: completions from the same channel to the same requester are delivered in arrival order. There is no ordering guarantee across channels.
- Reset mid-operation: all FIFO contents, locks and pending dealloc/err pulses are discarded. No output pulses after rst_n is asserted.

Test Plan:
- Single path: ch2 sends src=5, txnid=0x3A, db_id=7 at T, all wr_done_rdy=1.
  - Required: dealloc_vld[2]=1 with idx=7 at T+1.
  - Required: wr_done_vld[5]=1 with txnid=0x3A and chnl=2 at T+1; no other output active.
- Contention and round robin: ch0..ch3 each send src=1 in the same cycle (txnids 0x10..0x13), rdy[1]=1.
  - Required: delivery order 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - Required: rr_ptr[1] ends at 0.
- Lock stability: wr_done_rdy[3]=0 while ch1 is presenting txnid 0x22 to output 3.
  - Stimulus: ch0 then delivers src=3, txnid 0x20.
  - Required: output 3 holds 0x22 and chnl=1 until rdy=1, then presents 0x20 the next cycle.
- Backpressure and FIFO full: wr_done_rdy[0]=0 while ch0 sends 3 completions to src=0.
  - Required: wr_rsp_rdy[0]=0 after the 2nd acceptance and the 3rd completion waits.
  - Required: after rdy[0]=1, all 3 are delivered in order and wr_rsp_rdy[0] returns to 1.
- Illegal source: with W_REQ_NUM=6, ch3 sends src=7, db_id=9.
  - Required: dealloc_vld[3] with idx=9 and src_err[3] each pulse once.
  - Required: wr_done_vld stays 0.
- Reset mid-flight: assert rst_n=0 with 2 entries queued on ch1.
  - Required: all outputs immediately 0 and wr_rsp_rdy=0.
  - Required: after release, the queued entries are never delivered and wr_rsp_rdy=1 one edge later.
